// File: rtl/mips_mc_control.sv
// mips_mc_control: multicycle MIPS main control FSM with memory wait states
module mips_mc_control #(
    parameter logic [5:0] OP_RTYPE = 6'h00,
    parameter logic [5:0] OP_LW    = 6'h23,
    parameter logic [5:0] OP_SW    = 6'h2B,
    parameter logic [5:0] OP_BEQ   = 6'h04,
    parameter logic [5:0] OP_J     = 6'h02,
    parameter logic [5:0] OP_ADDI  = 6'h08
) (
    input  logic       clk,
    input  logic       reset,
    input  logic [5:0] opCode,
    input  logic       memReady,
    output logic       IRWrite,
    output logic       PCWrite,
    output logic       PCWriteCond,
    output logic       IorD,
    output logic       MemRead,
    output logic       MemWrite,
    output logic       MemtoReg,
    output logic       RegDst,
    output logic       RegWrite,
    output logic       ALUSrcA,
    output logic [1:0] ALUSrcB,
    output logic [1:0] ALUOp,
    output logic [1:0] PCSource,
    output logic       illegalOp
);
    localparam logic [3:0] S_RESET  = 4'd0;
    localparam logic [3:0] S_FETCH  = 4'd1;
    localparam logic [3:0] S_DECODE = 4'd2;
    localparam logic [3:0] S_MEMADR = 4'd3;
    localparam logic [3:0] S_MEMRD  = 4'd4;
    localparam logic [3:0] S_MEMWB  = 4'd5;
    localparam logic [3:0] S_MEMWR  = 4'd6;
    localparam logic [3:0] S_EXEC   = 4'd7;
    localparam logic [3:0] S_ALUWB  = 4'd8;
    localparam logic [3:0] S_BRANCH = 4'd9;
    localparam logic [3:0] S_JUMP   = 4'd10;
    localparam logic [3:0] S_ADDIEX = 4'd11;
    localparam logic [3:0] S_ADDIWB = 4'd12;

    logic [3:0] state, next;

    always_ff @(posedge clk or posedge reset)
        if (reset) state <= S_RESET;
        else       state <= next;

    always_comb begin
        next        = S_FETCH;
        IRWrite     = 1'b0;
        PCWrite     = 1'b0;
        PCWriteCond = 1'b0;
        IorD        = 1'b0;
        MemRead     = 1'b0;
        MemWrite    = 1'b0;
        MemtoReg    = 1'b0;
        RegDst      = 1'b0;
        RegWrite    = 1'b0;
        ALUSrcA     = 1'b0;
        ALUSrcB     = 2'b00;
        ALUOp       = 2'b00;
        PCSource    = 2'b00;
        illegalOp   = 1'b0;
        case (state)
            S_FETCH: begin
                MemRead = 1'b1;
                ALUSrcB = 2'b01;
                IRWrite = memReady;
                PCWrite = memReady;
                next    = memReady ? S_DECODE : S_FETCH;
            end
            S_DECODE: begin
                ALUSrcB   = 2'b11;
                next      = (opCode == OP_LW || opCode == OP_SW) ? S_MEMADR :
                            (opCode == OP_RTYPE) ? S_EXEC   :
                            (opCode == OP_BEQ)   ? S_BRANCH :
                            (opCode == OP_J)     ? S_JUMP   :
                            (opCode == OP_ADDI)  ? S_ADDIEX : S_FETCH;
                // unsupported opcodes fall back to FETCH and act as a NOP
                illegalOp = (next == S_FETCH);
            end
            S_MEMADR: begin
                ALUSrcA = 1'b1;
                ALUSrcB = 2'b10;
                next    = (opCode == OP_LW) ? S_MEMRD : S_MEMWR;
            end
            S_MEMRD: begin
                MemRead = 1'b1;
                IorD    = 1'b1;
                next    = memReady ? S_MEMWB : S_MEMRD;
            end
            S_MEMWB: begin
                RegWrite = 1'b1;
                MemtoReg = 1'b1;
            end
            S_MEMWR: begin
                MemWrite = 1'b1;
                IorD     = 1'b1;
                next     = memReady ? S_FETCH : S_MEMWR;
            end
            S_EXEC: begin
                ALUSrcA = 1'b1;
                ALUOp   = 2'b10;
                next    = S_ALUWB;
            end
            S_ALUWB: begin
                RegWrite = 1'b1;
                RegDst   = 1'b1;
            end
            S_BRANCH: begin
                ALUSrcA     = 1'b1;
                ALUOp       = 2'b01;
                PCWriteCond = 1'b1;
                PCSource    = 2'b01;
            end
            S_JUMP: begin
                PCWrite  = 1'b1;
                PCSource = 2'b10;
            end
            S_ADDIEX: begin
                ALUSrcA = 1'b1;
                ALUSrcB = 2'b10;
                next    = S_ADDIWB;
            end
            S_ADDIWB: RegWrite = 1'b1;
            default: next = S_FETCH;
        endcase
    end
endmodule

// File: tb/tb_mips_mc_control.sv
// tb_mips_mc_control: directed cycle-by-cycle checks of the multicycle control outputs
module tb_mips_mc_control;
    logic       clk = 1'b0;
    logic       reset;
    logic [5:0] opCode;
    logic       memReady;
    logic       IRWrite, PCWrite, PCWriteCond, IorD, MemRead, MemWrite;
    logic       MemtoReg, RegDst, RegWrite, ALUSrcA, illegalOp;
    logic [1:0] ALUSrcB, ALUOp, PCSource;
    int         pass_cnt = 0;
    int         total = 0;

    mips_mc_control dut (
        .clk(clk), .reset(reset), .opCode(opCode), .memReady(memReady),
        .IRWrite(IRWrite), .PCWrite(PCWrite), .PCWriteCond(PCWriteCond), .IorD(IorD),
        .MemRead(MemRead), .MemWrite(MemWrite), .MemtoReg(MemtoReg), .RegDst(RegDst),
        .RegWrite(RegWrite), .ALUSrcA(ALUSrcA), .ALUSrcB(ALUSrcB), .ALUOp(ALUOp),
        .PCSource(PCSource), .illegalOp(illegalOp)
    );

    always #5 clk = ~clk;

    // {IRWrite,PCWrite,PCWriteCond,IorD,MemRead,MemWrite,MemtoReg,RegDst,RegWrite,ALUSrcA,ALUSrcB,ALUOp,PCSource,illegalOp}
    logic [16:0] outs;
    assign outs = {IRWrite, PCWrite, PCWriteCond, IorD, MemRead, MemWrite, MemtoReg, RegDst,
                   RegWrite, ALUSrcA, ALUSrcB, ALUOp, PCSource, illegalOp};

    localparam logic [16:0] ZERO = 17'b0;
    localparam logic [16:0] FR   = 17'b1_1_0_0_1_0_0_0_0_0_01_00_00_0;
    localparam logic [16:0] FS   = 17'b0_0_0_0_1_0_0_0_0_0_01_00_00_0;
    localparam logic [16:0] DC   = 17'b0_0_0_0_0_0_0_0_0_0_11_00_00_0;
    localparam logic [16:0] DI   = 17'b0_0_0_0_0_0_0_0_0_0_11_00_00_1;
    localparam logic [16:0] MA   = 17'b0_0_0_0_0_0_0_0_0_1_10_00_00_0;
    localparam logic [16:0] MR   = 17'b0_0_0_1_1_0_0_0_0_0_00_00_00_0;
    localparam logic [16:0] MB   = 17'b0_0_0_0_0_0_1_0_1_0_00_00_00_0;
    localparam logic [16:0] MW   = 17'b0_0_0_1_0_1_0_0_0_0_00_00_00_0;
    localparam logic [16:0] EX   = 17'b0_0_0_0_0_0_0_0_0_1_00_10_00_0;
    localparam logic [16:0] AW   = 17'b0_0_0_0_0_0_0_1_1_0_00_00_00_0;
    localparam logic [16:0] BR   = 17'b0_0_1_0_0_0_0_0_0_1_00_01_01_0;
    localparam logic [16:0] JP   = 17'b0_1_0_0_0_0_0_0_0_0_00_00_10_0;
    localparam logic [16:0] IW   = 17'b0_0_0_0_0_0_0_0_1_0_00_00_00_0;

    task automatic next_cycle();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        next_cycle();
        #1;
        total++;
        if (outs !== ZERO) $display("FAIL reset_hold: got %h want %h", outs, ZERO);
        else pass_cnt++;
        reset = 1'b0;
        #1;
        total++;
        if (outs !== ZERO) $display("FAIL reset_state: got %h want %h", outs, ZERO);
        else pass_cnt++;
        next_cycle();
        opCode = 6'h23;
        memReady = 1'b1;
        #1;
        total++;
        if (outs !== FR) $display("FAIL reset_first_fetch: got %h want %h", outs, FR);
        else pass_cnt++;
        next_cycle();
        next_cycle();
        next_cycle();
        memReady = 1'b0;
        #1;
        total++;
        if (outs !== MR) $display("FAIL reset_in_memrd: got %h want %h", outs, MR);
        else pass_cnt++;
        reset = 1'b1;
        #1;
        total++;
        if (outs !== ZERO) $display("FAIL reset_async: got %h want %h", outs, ZERO);
        else pass_cnt++;
        next_cycle();
        reset = 1'b0;
        #1;
        total++;
        if (outs !== ZERO) $display("FAIL reset_restart: got %h want %h", outs, ZERO);
        else pass_cnt++;
        next_cycle();
        #1;
        total++;
        if (outs !== FS) $display("FAIL reset_refetch: got %h want %h", outs, FS);
        else pass_cnt++;
        next_cycle();
    endtask

    task automatic test_rtype();
        logic [16:0] e [5] = '{FR, DC, EX, AW, FS};
        logic        r [5] = '{1'b1, 1'b1, 1'b1, 1'b1, 1'b0};
        opCode = 6'h00;
        for (int i = 0; i < 5; i++) begin
            memReady = r[i];
            #1;
            total++;
            if (outs !== e[i]) $display("FAIL rtype cyc%0d: got %h want %h", i, outs, e[i]);
            else pass_cnt++;
            next_cycle();
        end
    endtask

    task automatic test_lw_wait();
        logic [16:0] e [9] = '{FR, DC, MA, MR, MR, MR, MR, MB, FS};
        logic        r [9] = '{1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0};
        opCode = 6'h23;
        for (int i = 0; i < 9; i++) begin
            memReady = r[i];
            #1;
            total++;
            if (outs !== e[i]) $display("FAIL lw_wait cyc%0d: got %h want %h", i, outs, e[i]);
            else pass_cnt++;
            next_cycle();
        end
    endtask

    task automatic test_sw_beq();
        logic [16:0] e [9] = '{FR, DC, MA, MW, FR, DC, BR, FS, FS};
        logic [5:0]  o [9] = '{6'h2B, 6'h2B, 6'h2B, 6'h2B, 6'h04, 6'h04, 6'h04, 6'h04, 6'h04};
        logic        r [9] = '{1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0};
        for (int i = 0; i < 9; i++) begin
            opCode = o[i];
            memReady = r[i];
            #1;
            total++;
            if (outs !== e[i]) $display("FAIL sw_beq cyc%0d: got %h want %h", i, outs, e[i]);
            else pass_cnt++;
            next_cycle();
        end
    endtask

    task automatic test_j_addi();
        logic [16:0] e [8] = '{FR, DC, JP, FR, DC, MA, IW, FS};
        logic [5:0]  o [8] = '{6'h02, 6'h02, 6'h02, 6'h08, 6'h08, 6'h08, 6'h08, 6'h08};
        for (int i = 0; i < 8; i++) begin
            opCode = o[i];
            memReady = (i != 7);
            #1;
            total++;
            if (outs !== e[i]) $display("FAIL j_addi cyc%0d: got %h want %h", i, outs, e[i]);
            else pass_cnt++;
            next_cycle();
        end
    endtask

    task automatic test_illegal_stall();
        logic [16:0] e [10] = '{FR, DI, FS, FS, FS, FS, FS, FR, DI, FS};
        logic        r [10] = '{1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0};
        opCode = 6'h3F;
        for (int i = 0; i < 10; i++) begin
            memReady = r[i];
            #1;
            total++;
            if (outs !== e[i]) $display("FAIL illegal_stall cyc%0d: got %h want %h", i, outs, e[i]);
            else pass_cnt++;
            next_cycle();
        end
    endtask

    task automatic test_back_to_back();
        logic [16:0] e [12] = '{FR, DC, EX, AW, FR, DC, MA, MW, MW, FR, DC, JP};
        logic [5:0]  o [12] = '{6'h00, 6'h00, 6'h00, 6'h00, 6'h2B, 6'h2B, 6'h2B, 6'h2B,
                                6'h2B, 6'h02, 6'h02, 6'h02};
        for (int i = 0; i < 12; i++) begin
            opCode = o[i];
            memReady = (i != 7);
            #1;
            total++;
            if (outs !== e[i]) $display("FAIL back_to_back cyc%0d: got %h want %h", i, outs, e[i]);
            else pass_cnt++;
            next_cycle();
        end
        memReady = 1'b0;
        #1;
        total++;
        if (outs !== FS) $display("FAIL back_to_back_end: got %h want %h", outs, FS);
        else pass_cnt++;
    endtask

    initial begin
        reset = 1'b1;
        opCode = 6'h00;
        memReady = 1'b1;
        test_reset();
        test_rtype();
        test_lw_wait();
        test_sw_beq();
        test_j_addi();
        test_illegal_stall();
        test_back_to_back();
        $display("%0d/%0d checks passed", pass_cnt, total);
        $finish;
    end
endmodule
